// File: rtl/memory_master_if.sv
// memory_master_if: bundles the command, write-data, read-data, status and
// memory-side signals of the burst initiator.
//   req_*       burst request (valid/ready), direction, start address, length-1
//   wr_*        write data stream (valid/ready)
//   rd_*        read data stream (valid/ready)
//   busy, done  status: busy outside IDLE, one-cycle pulse at burst completion
//   mem_*       single-port memory strobes; mem_data_out comes from the memory
// master: the burst initiator's view. slave: the datapath/memory view.
interface memory_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
           rd_ready, mem_data_out,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_enable, mem_read_write, mem_address, mem_data_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
           rd_ready, mem_data_out,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_enable, mem_read_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/memory_master.sv
// memory_master: burst initiator for a level-sensitive single-port memory.
// Accepts one burst at a time, streams write data in / read data out, and
// sequences Enable so address, data and direction are settled a full cycle
// before every strobe.
// Ports:
//   i_clk   single clock, rising edge
//   i_rst   asynchronous active-high reset; drops the memory strobe at once
//   io_bus  memory_master_if.master (request, write, read, status, memory)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a request, memory idle in read mode
// S_WDATA  | waiting for the next write word
// S_SETUP  | strobe low, address/data/direction settling
// S_STROBE | strobe high (1 cycle write, READ_WAIT cycles read)
// S_RESP   | read word presented, waiting for the consumer
// S_DONE   | one-cycle completion pulse, direction returns to read
module memory_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  memory_master_if.master  io_bus
);

  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_STROBE, S_RESP, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_write;
  logic              r_first;
  logic [8:0]        r_beats;
  logic [WAIT_W-1:0] r_wait;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_done;
  logic              r_en;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_in;

  logic w_req_hs;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_last_beat;

  assign w_req_hs    = io_bus.req_valid & r_req_ready;
  assign w_wr_hs     = io_bus.wr_valid & r_wr_ready;
  assign w_rd_hs     = io_bus.rd_ready & r_rd_valid;
  assign w_last_beat = (r_beats == 9'd1);

  // Memory-side registers are only updated on edges where the strobe is low
  // both before and after. For writes the next-address increment is
  // therefore deferred from the end of STROBE to the next data handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_first     <= 1'b0;
      r_beats     <= '0;
      r_wait      <= '0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_en        <= 1'b0;
      r_rw        <= 1'b1;
      r_addr      <= '0;
      r_data_in   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_write     <= io_bus.req_write;
            r_beats     <= {1'b0, io_bus.req_len} + 9'd1;
            r_addr      <= io_bus.req_addr;
            r_first     <= 1'b1;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (io_bus.req_write) begin
              r_wr_ready <= 1'b1;
              r_state    <= S_WDATA;
            end else begin
              r_rw    <= 1'b1;
              r_state <= S_SETUP;
            end
          end
        end
        S_WDATA: begin
          if (w_wr_hs) begin
            r_data_in  <= io_bus.wr_data;
            r_rw       <= 1'b0;
            r_wr_ready <= 1'b0;
            r_first    <= 1'b0;
            if (!r_first) r_addr <= r_addr + ADDR_W'(1);
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_en    <= 1'b1;
          r_wait  <= WAIT_W'(READ_WAIT - 1);
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (r_write) begin
            r_en <= 1'b0;
            if (w_last_beat) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beats    <= r_beats - 9'd1;
              r_wr_ready <= 1'b1;
              r_state    <= S_WDATA;
            end
          end else if (r_wait == '0) begin
            r_en       <= 1'b0;
            r_rd_data  <= io_bus.mem_data_out;
            r_rd_valid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_RESP: begin
          if (w_rd_hs) begin
            r_rd_valid <= 1'b0;
            if (w_last_beat) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beats <= r_beats - 9'd1;
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          r_rw        <= 1'b1;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready      = r_req_ready;
  assign io_bus.wr_ready       = r_wr_ready;
  assign io_bus.rd_valid       = r_rd_valid;
  assign io_bus.rd_data        = r_rd_data;
  assign io_bus.busy           = r_busy;
  assign io_bus.done           = r_done;
  assign io_bus.mem_enable     = r_en;
  assign io_bus.mem_read_write = r_rw;
  assign io_bus.mem_address    = r_addr;
  assign io_bus.mem_data_in    = r_data_in;

endmodule

// File: tb/tb_memory_master.sv
module tb_memory_master;

  localparam int RW = 2;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  memory_master_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  memory_master #(.ADDR_W(16), .DATA_W(32), .READ_WAIT(RW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: writes on the clock edge while enabled in write mode,
  // read data only valid after Enable has been high READ_WAIT-1 cycles
  logic [31:0] mem [0:65535];
  int          en_cnt = 0;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {16'h5A5A, a};
  endfunction

  initial for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));

  always @(posedge clk) begin
    if (bus.mem_enable && !bus.mem_read_write) mem[bus.mem_address] <= bus.mem_data_in;
    en_cnt <= bus.mem_enable ? en_cnt + 1 : 0;
  end

  assign bus.mem_data_out = (bus.mem_enable && bus.mem_read_write && en_cnt >= RW - 1)
                            ? mem[bus.mem_address] : 32'hDEAD_BEEF;

  // bus monitor
  int          pulses = 0, setup_bad = 0, dbl_wr = 0, chg_bad = 0, hold_bad = 0, done_cnt = 0;
  logic        p_rst = 1'b1, p_en = 1'b0, p_rw = 1'b1, p_rv = 1'b0, p_rr = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_din = '0, p_rdata = '0;

  always @(negedge clk) begin
    logic chg;
    chg = (bus.mem_address != p_addr) || (bus.mem_data_in != p_din) ||
          (bus.mem_read_write != p_rw);
    if (!rst && !p_rst) begin
      if (bus.mem_enable && !p_en) begin
        pulses++;
        if (chg) setup_bad++;
      end
      if (bus.mem_enable && p_en && !bus.mem_read_write && !p_rw) dbl_wr++;
      if (chg && (bus.mem_enable || p_en)) chg_bad++;
      if (p_rv && !p_rr && bus.rd_valid && bus.rd_data != p_rdata) hold_bad++;
      if (bus.done) done_cnt++;
    end
    p_rst   = rst;
    p_en    = bus.mem_enable;
    p_rw    = bus.mem_read_write;
    p_addr  = bus.mem_address;
    p_din   = bus.mem_data_in;
    p_rv    = bus.rd_valid;
    p_rr    = bus.rd_ready;
    p_rdata = bus.rd_data;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [15:0] a, input logic [7:0] len);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = len;
    while (!bus.req_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check_eq("req_timeout", 64'(n), 0);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] d);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    while (!bus.wr_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check_eq("wr_timeout", 64'(n), 0);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.req_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check_eq("idle_timeout", 64'(n), 0);
    tick();
  endtask

  logic [31:0] rq[$];

  task automatic read_burst(input logic [15:0] a, input logic [7:0] len, input bit toggle);
    int beats = 0;
    int n = 0;
    rq.delete();
    send_req(1'b0, a, len);
    bus.rd_ready = 1'b0;
    while (beats <= int'(len) && n < 500) begin
      bus.rd_ready = toggle ? ~bus.rd_ready : 1'b1;
      if (bus.rd_valid && bus.rd_ready) begin
        rq.push_back(bus.rd_data);
        beats++;
      end
      tick();
      n++;
    end
    bus.rd_ready = 1'b0;
    check_eq("rd_beats", 64'(beats), 64'(int'(len) + 1));
  endtask

  initial begin
    int p0, d0, viol, lat;
    logic [15:0] stall_addr;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid  = 1'b0; bus.wr_data   = '0;   bus.rd_ready = 1'b0;

    // reset state, checked before the first clock edge
    rst = 1'b1;
    #3;
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_wr_ready", bus.wr_ready, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_mem_en", bus.mem_enable, 0);
    check_eq("rst_mem_rw", bus.mem_read_write, 1);
    check_eq("rst_mem_addr", bus.mem_address, 0);
    check_eq("rst_mem_din", bus.mem_data_in, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rel_req_ready", bus.req_ready, 1);

    // 4-beat write at 0x0010
    p0 = pulses; d0 = done_cnt;
    send_req(1'b1, 16'h0010, 8'd3);
    check_eq("wr_busy_t1", bus.busy, 1);
    for (int i = 0; i < 4; i++) write_beat(32'hA0 + 32'(i));
    wait_idle();
    for (int i = 0; i < 4; i++) check_eq("wr_mem", mem[16'h0010 + 16'(i)], 32'hA0 + 32'(i));
    check_eq("wr_mem_below", mem[16'h000F], init_val(16'h000F));
    check_eq("wr_mem_above", mem[16'h0014], init_val(16'h0014));
    check_eq("wr_pulses", 64'(pulses - p0), 4);
    check_eq("wr_done_cnt", 64'(done_cnt - d0), 1);

    // read-back with toggling consumer
    d0 = done_cnt;
    read_burst(16'h0010, 8'd3, 1'b1);
    wait_idle();
    check_eq("rd_count", 64'(rq.size()), 4);
    for (int i = 0; i < 4 && i < rq.size(); i++) check_eq("rd_data", rq[i], 32'hA0 + 32'(i));
    check_eq("rd_done_cnt", 64'(done_cnt - d0), 1);

    // wrap-around write
    send_req(1'b1, 16'hFFFE, 8'd3);
    for (int i = 0; i < 4; i++) write_beat(32'hB0 + 32'(i));
    wait_idle();
    check_eq("wrap_fffe", mem[16'hFFFE], 32'hB0);
    check_eq("wrap_ffff", mem[16'hFFFF], 32'hB1);
    check_eq("wrap_0000", mem[16'h0000], 32'hB2);
    check_eq("wrap_0001", mem[16'h0001], 32'hB3);
    check_eq("wrap_fffd", mem[16'hFFFD], init_val(16'hFFFD));
    check_eq("wrap_0002", mem[16'h0002], init_val(16'h0002));

    // single-beat read latency: SETUP, READ_WAIT strobes, then RdValid
    send_req(1'b0, 16'hFFFF, 8'd0);
    check_eq("rd1_busy", bus.busy, 1);
    lat = 0;
    while (!bus.rd_valid && lat < 50) begin tick(); lat++; end
    check_eq("rd1_latency", 64'(lat), 64'(RW + 1));
    check_eq("rd1_data", bus.rd_data, 32'hB1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check_eq("rd1_done", bus.done, 1);
    tick();
    check_eq("rd1_req_ready", bus.req_ready, 1);

    // write stall of 10 cycles with a colliding request
    d0 = done_cnt;
    send_req(1'b1, 16'h0100, 8'd3);
    write_beat(32'hC0);
    write_beat(32'hC1);
    viol = 0;
    while (!bus.wr_ready && viol < 100) begin tick(); viol++; end
    stall_addr = bus.mem_address;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_enable || bus.mem_address != stall_addr) viol++;
      if (i == 4) begin
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0300; bus.req_len = 8'd0;
        check_eq("coll_req_ready", bus.req_ready, 0);
      end
      if (i == 5) bus.req_valid = 1'b0;
      tick();
    end
    check_eq("stall_viol", 64'(viol), 0);
    write_beat(32'hC2);
    write_beat(32'hC3);
    wait_idle();
    for (int i = 0; i < 4; i++) check_eq("stall_mem", mem[16'h0100 + 16'(i)], 32'hC0 + 32'(i));
    check_eq("stall_done_cnt", 64'(done_cnt - d0), 1);

    // reset during the third strobe of a 4-beat write
    d0 = done_cnt;
    send_req(1'b1, 16'h0200, 8'd3);
    write_beat(32'hD0);
    write_beat(32'hD1);
    write_beat(32'hD2);
    tick();
    check_eq("pre_rst_strobe", bus.mem_enable, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_mem_en", bus.mem_enable, 0);
    check_eq("arst_mem_rw", bus.mem_read_write, 1);
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_req_ready", bus.req_ready, 1);
    check_eq("arst_mem_addr", bus.mem_address, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check_eq("arst_mem_200", mem[16'h0200], 32'hD0);
    check_eq("arst_mem_201", mem[16'h0201], 32'hD1);
    check_eq("arst_mem_202", mem[16'h0202], init_val(16'h0202));
    check_eq("arst_mem_203", mem[16'h0203], init_val(16'h0203));
    check_eq("arst_no_done", 64'(done_cnt - d0), 0);
    check_eq("arst_rel_ready", bus.req_ready, 1);
    send_req(1'b1, 16'h0202, 8'd0);
    write_beat(32'hE0);
    wait_idle();
    check_eq("post_rst_mem", mem[16'h0202], 32'hE0);
    check_eq("post_rst_done", 64'(done_cnt - d0), 1);

    // bus invariants over the whole run
    check_eq("inv_setup", 64'(setup_bad), 0);
    check_eq("inv_dbl_wr", 64'(dbl_wr), 0);
    check_eq("inv_change", 64'(chg_bad), 0);
    check_eq("inv_rd_hold", 64'(hold_bad), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_master.md
# memory_master

Burst initiator that drives the level-sensitive single-port memory (Enable / ReadWrite / Address / DataIn / DataOut; Enable=1 with ReadWrite=1 reads, with ReadWrite=0 writes). It accepts one burst request at a time from a valid/ready command port and streams write data in or read data out over valid/ready data ports. It sequences the memory strobes so that a write can never hit an unintended address. It sits between the datapath and the memory and is the only block that drives the memory's control inputs.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 32, memory word width
- READ_WAIT, 1, cycles Enable is held high before DataOut is sampled (>=1)
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  burst request valid
- ReqReady  out  1  request accepted when ReqValid & ReqReady
- ReqWrite  in  1  1 = write burst, 0 = read burst
- ReqAddr  in  ADDR_W  start address
- ReqLen  in  8  beats minus 1 (0 = 1 beat, 255 = 256 beats)
- WrValid  in  1  write data valid
- WrReady  out  1  write data accepted when WrValid & WrReady
- WrData  in  DATA_W  write data
- RdValid  out  1  read data valid, held until RdReady
- RdReady  in  1  read data consumer ready
- RdData  out  DATA_W  read data
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse at burst completion
- MemEnable  out  1  to memory Enable
- MemReadWrite  out  1  to memory ReadWrite (1 read, 0 write)
- MemAddress  out  ADDR_W  to memory Address
- MemDataIn  out  DATA_W  to memory DataIn
- MemDataOut  in  DATA_W  from memory DataOut (high-Z when MemEnable=0)

## Operation
- States: IDLE, WDATA, SETUP, STROBE, RESP, DONE.
- IDLE: ReqReady=1. On a request handshake, latch ReqWrite, ReqAddr and ReqLen, and load MemAddress=ReqAddr.
  - Write burst: go to WDATA.
  - Read burst: go to SETUP with MemReadWrite=1.
- WDATA: WrReady=1. On a WrValid handshake, register WrData into MemDataIn, set MemReadWrite=0, go to SETUP.
- SETUP: MemEnable=0, with address, data and direction stable. Always lasts exactly 1 cycle, then go to STROBE.
- STROBE: MemEnable=1.
  - Write: lasts 1 cycle.
  - Read: lasts READ_WAIT cycles. MemDataOut is captured into RdData on the last STROBE cycle, then go to RESP.
- RESP: RdValid=1. On the RdReady handshake, advance the beat.
- Beat advance: if beats remain, MemAddress <= MemAddress+1 and go to WDATA (write) or SETUP (read). Otherwise go to DONE.
- DONE: Done=1 for 1 cycle, MemReadWrite returns to 1, then go to IDLE.
- Invariants:
  - MemAddress, MemDataIn and MemReadWrite change only on cycles where MemEnable is 0 in the current and the next cycle.
  - MemEnable is never high for two consecutive write cycles.
- Address arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000, with no error flag.
- Beat counter is 9 bits, so 256-beat bursts are legal.
- ReqValid outside IDLE is ignored (ReqReady=0). WrValid outside WDATA is ignored. RdReady is ignored while RdValid=0.
- Reset mid-burst: the burst is abandoned immediately (async) and MemEnable drops to 0 without waiting for a clock. Writes already strobed persist. No Done pulse.
- Reset values: state IDLE, ReqReady=1, WrReady=0, RdValid=0, RdData=0, Busy=0, Done=0, MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataIn=0.
- MemReadWrite idles at 1, so an idle or abandoned memory is never in write mode.

## Timing
- Request handshake at cycle t; Busy=1 from t+1.
- Write beat, WrValid held high: handshake at w, SETUP at w+1, STROBE at w+2, WrReady at w+3. Throughput is 3 cycles per beat.
- Read beat, RdReady held high: SETUP at s, STROBE at s+1..s+READ_WAIT, RdValid at s+READ_WAIT+1, next SETUP at s+READ_WAIT+2. Throughput is READ_WAIT+2 cycles per beat.
- Done asserts in the cycle after the final beat completes: after the last STROBE for writes, after the last RdValid&RdReady handshake for reads.
- ReqReady returns 1 in the cycle after Done. Minimum request-to-request spacing for a 1-beat write is 5 cycles.
- WrValid and RdReady stalls of any length are legal. Memory outputs are held with MemEnable=0 during stalls.

## Test plan
- Reset: assert Reset mid-cycle -> all outputs take their reset values without a clock edge, and ReqReady=1 after release.
- Write burst: ReqAddr=16'h0010, ReqLen=3, data 32'hA0..A3 -> mem[0x10..0x13]=A0..A3. MemEnable pulses exactly 4 times, each 1 cycle, and every pulse is preceded by a SETUP cycle with MemEnable=0. Done asserts once.
- Read-back with READ_WAIT=2 and RdReady toggling every other cycle: same address and length -> RdData sequence A0,A1,A2,A3, each held stable while RdValid=1 && RdReady=0.
- Wrap-around: write burst ReqAddr=16'hFFFE, ReqLen=3 -> writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001, and no other location changes.
- Back-pressure and collisions: WrValid withheld for 10 cycles mid-burst -> MemEnable stays 0 and MemAddress stays unchanged. ReqValid pulsed while Busy -> ignored.
- Reset after beat 2 of a 4-beat write -> mem holds beats 0 and 1 only, no Done pulse, and a new request is accepted after reset is released.
